// File: rtl/risc16_loader_pkg.sv
// Shared types and constants for the RISC-16 program loader.
// Optional checksum support is selected with RISC16_LOADER_CSUM_EN.
package risc16_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Address and count header fields are each this many bytes wide.
    localparam int unsigned WORD_BYTES = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_CNT_H,
        ST_CNT_L,
        ST_DATA_H,
        ST_DATA_L,
        ST_WRITE,
`ifdef RISC16_LOADER_CSUM_EN
        ST_CSUM,
`endif
        ST_RELEASE,
        ST_ERROR
    } state_t;

`ifdef RISC16_LOADER_CSUM_EN
    localparam state_t DONE_ST = ST_CSUM;
`else
    localparam state_t DONE_ST = ST_RELEASE;
`endif

endpackage

// File: rtl/risc16_pgm_loader_timer.sv
// Inter-byte idle counter; expired marks the TIMEOUT_CYC-th consecutive idle cycle.
module risc16_loader_timer #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt;

    assign expired = enable && (cnt == W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/risc16_pgm_loader.sv
// Framed byte-stream loader driving the RISC-16 program-memory port.
// Define RISC16_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module risc16_pgm_loader
    import risc16_loader_pkg::*;
#(
    parameter int unsigned RST_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        pgm,
    output logic [15:0] pgm_addr,
    output logic [15:0] pgm_data,
    output logic        pg_wr,
    output logic        cpu_rst,
    output logic        busy,
    output logic        err,
    output logic [15:0] words_loaded
);

    localparam int unsigned RW = $clog2(RST_CYC + 1);

    state_t                    state;
    logic [8*WORD_BYTES-1:0]   base_addr;
    logic [8*WORD_BYTES-1:0]   word_cnt;
    logic [7:0]                hi_byte;
    logic [RW-1:0]             rel_cnt;
    logic [15:0]               wl_next;
    logic                      accept;
    logic                      timed;
    logic                      expired;

    assign rx_ready = (state != ST_WRITE) && (state != ST_RELEASE);
    assign accept   = rx_valid && rx_ready;
    assign wl_next  = words_loaded + 16'd1;

    always_comb begin
        timed = 1'b0;
        case (state)
            ST_ADDR_H, ST_ADDR_L, ST_CNT_H, ST_CNT_L, ST_DATA_H, ST_DATA_L: timed = 1'b1;
`ifdef RISC16_LOADER_CSUM_EN
            ST_CSUM: timed = 1'b1;
`endif
            default: timed = 1'b0;
        endcase
    end

    risc16_loader_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept || !timed),
        .enable  (timed),
        .expired (expired)
    );

`ifdef RISC16_LOADER_CSUM_EN
    logic [7:0] acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            if (state == ST_IDLE || state == ST_ERROR) begin
                acc <= '0;
            end else if (state != ST_CSUM) begin
                acc <= acc ^ rx_data;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pgm          <= 1'b0;
            pgm_addr     <= '0;
            pgm_data     <= '0;
            pg_wr        <= 1'b0;
            cpu_rst      <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            base_addr    <= '0;
            word_cnt     <= '0;
            hi_byte      <= '0;
            rel_cnt      <= '0;
        end else begin
            pg_wr   <= 1'b0;
            rel_cnt <= '0;
            if (expired && !accept) begin
                state <= ST_ERROR;
                err   <= 1'b1;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_ERROR: begin
                        if (accept && rx_data == SYNC_BYTE) begin
                            state        <= ST_ADDR_H;
                            pgm          <= 1'b1;
                            busy         <= 1'b1;
                            err          <= 1'b0;
                            words_loaded <= '0;
                        end
                    end
                    ST_ADDR_H: if (accept) begin base_addr[15:8] <= rx_data; state <= ST_ADDR_L; end
                    ST_ADDR_L: if (accept) begin base_addr[7:0]  <= rx_data; state <= ST_CNT_H;  end
                    ST_CNT_H:  if (accept) begin word_cnt[15:8]  <= rx_data; state <= ST_CNT_L;  end
                    ST_CNT_L: begin
                        if (accept) begin
                            word_cnt[7:0] <= rx_data;
                            if ({word_cnt[15:8], rx_data} == 16'd0) begin
                                state   <= DONE_ST;
                                cpu_rst <= (DONE_ST == ST_RELEASE);
                            end else begin
                                state <= ST_DATA_H;
                            end
                        end
                    end
                    ST_DATA_H: if (accept) begin hi_byte <= rx_data; state <= ST_DATA_L; end
                    ST_DATA_L: begin
                        if (accept) begin
                            pg_wr    <= 1'b1;
                            pgm_addr <= base_addr + words_loaded;
                            pgm_data <= {hi_byte, rx_data};
                            state    <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        words_loaded <= wl_next;
                        if (wl_next == word_cnt) begin
                            state   <= DONE_ST;
                            cpu_rst <= (DONE_ST == ST_RELEASE);
                        end else begin
                            state <= ST_DATA_H;
                        end
                    end
`ifdef RISC16_LOADER_CSUM_EN
                    ST_CSUM: begin
                        if (accept) begin
                            if (rx_data == acc) begin
                                state   <= ST_RELEASE;
                                cpu_rst <= 1'b1;
                            end else begin
                                state <= ST_ERROR;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end
`endif
                    ST_RELEASE: begin
                        if (rel_cnt == RW'(RST_CYC - 1)) begin
                            pgm     <= 1'b0;
                            cpu_rst <= 1'b0;
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            rel_cnt <= rel_cnt + RW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_risc16_pgm_loader.sv
// Self-checking bench for risc16_pgm_loader; honours RISC16_LOADER_CSUM_EN when defined.
module tb_risc16_pgm_loader;

    localparam int unsigned RST_C = 4;
    localparam int unsigned TO_C  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, pgm, pg_wr, cpu_rst, busy, err;
    logic [15:0] pgm_addr, pgm_data, words_loaded;

    int n_chk = 0;
    int n_err = 0;

    risc16_pgm_loader #(.RST_CYC(RST_C), .TIMEOUT_CYC(TO_C)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .pgm(pgm), .pgm_addr(pgm_addr), .pgm_data(pgm_data), .pg_wr(pg_wr),
        .cpu_rst(cpu_rst), .busy(busy), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model: frame position, bubbles and countdowns
    logic        m_ready = 1'b1, m_pgm = 1'b0, m_wr = 1'b0, m_crst = 1'b0, m_busy = 1'b0, m_err = 1'b0;
    logic [15:0] m_addr = '0, m_data = '0, m_wl = '0, m_base = '0, m_cnt = '0;
    logic [7:0]  m_hi = '0, m_x = '0;
    int          m_pos = -1;       // -1: hunting for sync; else bytes consumed after sync
    bit          m_in_write = 0, m_csum_wait = 0, m_acc = 0;
    int          m_rel_left = 0, m_idle = 0;

    task automatic m_release();
        m_pos = -1; m_rel_left = RST_C; m_crst = 1'b1;
    endtask

    task automatic m_fail();
        m_pos = -1; m_err = 1'b1; m_busy = 1'b0; m_csum_wait = 0;
    endtask

    task automatic m_finish();
`ifdef RISC16_LOADER_CSUM_EN
        m_csum_wait = 1;
`else
        m_release();
`endif
    endtask

    task automatic m_consume(input logic [7:0] b);
        if (m_csum_wait) begin
            m_csum_wait = 0;
            if (b == m_x) m_release(); else m_fail();
        end else begin
            m_x = m_x ^ b;
            case (m_pos)
                0: m_base[15:8] = b;
                1: m_base[7:0]  = b;
                2: m_cnt[15:8]  = b;
                3: m_cnt[7:0]   = b;
                default: begin
                    if (((m_pos - 4) % 2) == 0) m_hi = b;
                    else begin
                        m_wr = 1'b1; m_addr = m_base + m_wl; m_data = {m_hi, b}; m_in_write = 1;
                    end
                end
            endcase
            m_pos++;
            if (m_pos == 4 && m_cnt == 16'd0) m_finish();
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1; m_pgm = 0; m_wr = 0; m_crst = 0; m_busy = 0; m_err = 0;
            m_addr = '0; m_data = '0; m_wl = '0; m_pos = -1; m_in_write = 0;
            m_csum_wait = 0; m_rel_left = 0; m_idle = 0;
        end else begin
            m_acc = m_ready && rx_valid;
            m_wr  = 1'b0;
            if (m_rel_left > 0) begin
                m_rel_left--;
                if (m_rel_left == 0) begin m_pgm = 0; m_crst = 0; m_busy = 0; end
            end else if (m_in_write) begin
                m_in_write = 0; m_idle = 0; m_wl = m_wl + 16'd1;
                if (m_wl == m_cnt) m_finish();
            end else if (m_pos < 0) begin
                if (m_acc && rx_data == 8'hA5) begin
                    m_pos = 0; m_pgm = 1; m_busy = 1; m_err = 0; m_wl = '0;
                    m_x = '0; m_idle = 0; m_csum_wait = 0;
                end
            end else if (m_acc) begin
                m_idle = 0;
                m_consume(rx_data);
            end else begin
                m_idle++;
                if (m_idle == TO_C) m_fail();
            end
            m_ready = !(m_in_write || m_rel_left > 0);
        end
    end

    // ---------------- per-cycle compare and event monitor
    function automatic logic [53:0] dut_vec();
        return {rx_ready, pgm, pgm_addr, pgm_data, pg_wr, cpu_rst, busy, err, words_loaded};
    endfunction

    logic [31:0] wr_q[$];
    int          crst_cycles = 0;

    always @(negedge clk) begin
        logic [53:0] ev;
        ev = {m_ready, m_pgm, m_addr, m_data, m_wr, m_crst, m_busy, m_err, m_wl};
        n_chk++;
        if (dut_vec() !== ev) begin
            n_err++;
            $display("FAIL cycle_outputs t=%0t got rdy,pgm,addr,data,wr,crst,busy,err,wl=%h expected %h",
                     $time, dut_vec(), ev);
        end
        if (pg_wr === 1'b1) wr_q.push_back({pgm_addr, pgm_data});
        if (cpu_rst === 1'b1) crst_cycles++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- stimulus helpers (all return #1 after a rising edge)
    logic [7:0]  fq[$];
    logic [15:0] wq[$];

    task automatic mk_frame(input logic [15:0] addr);
        logic [15:0] n;
        n = 16'(wq.size());
        fq = '{8'hA5, addr[15:8], addr[7:0], n[15:8], n[7:0]};
        foreach (wq[i]) begin fq.push_back(wq[i][15:8]); fq.push_back(wq[i][7:0]); end
`ifdef RISC16_LOADER_CSUM_EN
        begin
            logic [7:0] x;
            x = '0;
            for (int i = 1; i < fq.size(); i++) x = x ^ fq[i];
            fq.push_back(x);
        end
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit ok, r;
        ok = 0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_valid = 1'b1; rx_data = b;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk); r = rx_ready;
            @(posedge clk); #1;
            ok = r;
        end
        rx_valid = 1'b0; rx_data = 8'($urandom);
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL handshake: byte %h not accepted, ready got 0 expected 1", b);
        end
    endtask

    task automatic send_n(input int n, input int unsigned maxgap);
        for (int i = 0; i < n; i++) send_byte(fq[i], $urandom_range(0, maxgap));
    endtask

    task automatic wait_done();
        bit done;
        done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (!busy && !cpu_rst) done = 1;
            else begin @(posedge clk); #1; end
        end
        if (!done) begin
            n_chk++; n_err++;
            $display("FAIL release_wait: busy got 1 expected 0 within 300 cycles");
        end
    endtask

    task automatic clr();
        wr_q.delete(); crst_cycles = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'(dut_vec()), 64'({1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0}));
        rst = 1'b0;

        // Basic two-word frame at full rate
        clr(); wq = '{16'h1234, 16'hABCD}; mk_frame(16'h000F);
        send_n(fq.size(), 0); wait_done();
        chk("a_nwrites", 64'(wr_q.size()), 64'd2);
        if (wr_q.size() == 2) begin
            chk("a_write0", 64'(wr_q[0]), 64'h000F_1234);
            chk("a_write1", 64'(wr_q[1]), 64'h0010_ABCD);
        end
        chk("a_words_loaded", 64'(words_loaded), 64'd2);
        chk("a_crst_cycles", 64'(crst_cycles), 64'(RST_C));
        chk("a_pgm_released", 64'(pgm), 64'd0);

        // Address wrap, sync value carried as data
        clr(); wq = '{16'hA5A5, 16'h0102}; mk_frame(16'hFFFF);
        send_n(fq.size(), 2); wait_done();
        chk("wrap_nwrites", 64'(wr_q.size()), 64'd2);
        if (wr_q.size() == 2) begin
            chk("wrap_write0", 64'(wr_q[0]), 64'hFFFF_A5A5);
            chk("wrap_write1", 64'(wr_q[1]), 64'h0000_0102);
        end

        // Empty frame
        clr(); wq.delete(); mk_frame(16'h1000);
        send_n(fq.size(), 1); wait_done();
        chk("cnt0_nwrites", 64'(wr_q.size()), 64'd0);
        chk("cnt0_crst_cycles", 64'(crst_cycles), 64'(RST_C));

        // Stall after ADDR_L until timeout, then recover
        clr(); wq = '{16'h1111}; mk_frame(16'h0010);
        send_n(3, 0);
        repeat (TO_C + 2) @(posedge clk);
        #1;
        chk("to_err", 64'(err), 64'd1);
        chk("to_pgm_held", 64'(pgm), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_ready", 64'(rx_ready), 64'd1);
        clr(); send_byte(8'h3C, 0);
        wq = '{16'h5555, 16'h6666}; mk_frame(16'h0200);
        send_n(fq.size(), 1); wait_done();
        chk("rec_err", 64'(err), 64'd0);
        chk("rec_nwrites", 64'(wr_q.size()), 64'd2);
        chk("rec_crst_cycles", 64'(crst_cycles), 64'(RST_C));

        // Reset between DATA_H and DATA_L
        clr(); wq = '{16'h1234}; mk_frame(16'h0020);
        send_n(6, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_state", 64'(dut_vec()), 64'({1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0}));
        rst = 1'b0;
        send_byte(8'h34, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_nwrites", 64'(wr_q.size()), 64'd0);
        chk("midrst_pgm", 64'(pgm), 64'd0);

`ifdef RISC16_LOADER_CSUM_EN
        // Corrupted checksum: error, no release, memory already written stays
        clr(); wq = '{16'h0BAD}; mk_frame(16'h0300);
        fq[fq.size() - 1] = fq[fq.size() - 1] ^ 8'h01;
        send_n(fq.size(), 0); wait_done();
        chk("csum_bad_err", 64'(err), 64'd1);
        chk("csum_bad_crst", 64'(crst_cycles), 64'd0);
        chk("csum_bad_pgm", 64'(pgm), 64'd1);
        chk("csum_bad_nwrites", 64'(wr_q.size()), 64'd1);
`endif

        // Randomised frames with gaps, junk bytes and (optionally) bad checksums
        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, $urandom_range(0, 2));
            end
            wq.delete();
            repeat ($urandom_range(0, 5)) wq.push_back(($urandom_range(0, 3) == 0) ? 16'hA5A5 : 16'($urandom));
            mk_frame(16'($urandom));
`ifdef RISC16_LOADER_CSUM_EN
            if ($urandom_range(0, 4) == 0) fq[fq.size() - 1] = fq[fq.size() - 1] ^ 8'h80;
`endif
            send_n(fq.size(), 3);
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/risc16_pgm_loader.md
# risc16_pgm_loader

Byte-stream program loader that sequences the RISC-16 memory-programming port. It receives a framed image over an 8-bit valid/ready stream and holds the CPU in program mode while the image is written. Each word is written into RAM through `pgm_addr`/`pgm_data`/`pg_wr`. On completion it pulses CPU reset and releases the CPU so execution restarts at `PROG_START`.

## Interface
Parameters:
- `RST_CYC`, default 4: cycles `cpu_rst` is held high during release (must be ≥1).
- `TIMEOUT_CYC`, default 50000: maximum idle cycles between bytes inside a frame before abort.

Ports:
- `clk`  in  1  system clock; this is the same clock that feeds the CPU `clk_in` and `pclk`.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  incoming stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `pgm`  out  1  CPU program-mode hold; drives the CPU `pgm` input.
- `pgm_addr`  out  16  RAM write address.
- `pgm_data`  out  16  RAM write data.
- `pg_wr`  out  1  one-cycle RAM write strobe.
- `cpu_rst`  out  1  CPU reset request, ORed into the CPU `rst` at top level.
- `busy`  out  1  frame in progress.
- `err`  out  1  sticky frame error.
- `words_loaded`  out  16  words written in the current or last frame.

## Operation
- A byte is accepted on any edge where `rx_valid && rx_ready`.
- Frame format, big-endian: sync `8'hA5`, ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT words sent as high byte followed by low byte. When checksum support is compiled in, a checksum byte follows the last word.
- States: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, WRITE, [CSUM], RELEASE, ERROR.
- IDLE: `rx_ready`=1. Non-sync bytes are discarded. Accepting `8'hA5` moves to ADDR_H, sets `pgm`=1 and `busy`=1, clears `err`, clears `words_loaded`, and clears the checksum accumulator.
- ADDR_H/ADDR_L latch the base address. CNT_H/CNT_L latch the word count.
- After CNT_L:
  - CNT=0 goes to CSUM (when compiled in) or to RELEASE.
  - Otherwise goes to DATA_H.
- DATA_H latches the high byte. Accepting the DATA_L byte moves to WRITE.
- WRITE lasts exactly one cycle:
  - `rx_ready`=0 and `pg_wr`=1.
  - `pgm_addr` = base + `words_loaded`, modulo 2^16, so addresses wrap from `FFFF` to `0000`.
  - `words_loaded` increments.
  - If `words_loaded+1` == CNT, go to CSUM or RELEASE; otherwise go to DATA_H.
- RELEASE: `rx_ready`=0 and `cpu_rst`=1 for `RST_CYC` cycles with `pgm` still 1. On the last of these cycles, `pgm`, `cpu_rst` and `busy` all clear together and the FSM returns to IDLE.
- Timeout: in ADDR_H through DATA_L and CSUM, an idle counter resets on every accepted byte. When it reaches `TIMEOUT_CYC`, the FSM goes to ERROR.
- ERROR:
  - `err`=1, `busy`=0, `pgm` stays 1 so the CPU remains held, and `rx_ready`=1.
  - Only a sync byte restarts a frame, following the same path as IDLE.
  - Memory already written is not rolled back.
- `pgm_data`/`pgm_addr` hold their last values outside WRITE.
- A sync value arriving inside a frame is treated as data, not as a resync.

## Timing
- Reset values: `rx_ready`=1, `pgm`=0, `pgm_addr`=0, `pgm_data`=0, `pg_wr`=0, `cpu_rst`=0, `busy`=0, `err`=0, `words_loaded`=0, state IDLE.
- `pgm` rises on the edge that accepts the sync byte.
- `pg_wr` is high in the cycle immediately after the DATA_L byte is accepted.
- Peak throughput is 3 cycles per word: two bytes plus the WRITE bubble.
- After the last word's WRITE (or after the checksum byte is accepted), `cpu_rst` is high for exactly `RST_CYC` cycles. `pgm` falls on the same edge as `cpu_rst`.
- `rst` mid-frame forces reset values on the next edge: `pgm` drops and no further `pg_wr` is issued.
- Timeout fires on the `TIMEOUT_CYC`-th consecutive idle cycle. An accepted byte in that same cycle wins and resets the counter.

## Configuration
- `RISC16_LOADER_CSUM_EN` defined:
  - The CSUM state is present.
  - The accumulator is the XOR of every byte after sync, covering header and data.
  - The trailing byte must equal the accumulator; a match goes to RELEASE, a mismatch goes to ERROR.
- Undefined: no CSUM state and no accumulator. The last WRITE, or CNT=0, goes directly to RELEASE.

## Structure
- Package `risc16_loader_pkg`: state enum, the `SYNC_BYTE` constant `8'hA5`, and the frame-field byte-count constant.
- One sub-module, `risc16_loader_timer`: the idle/timeout counter with a clear input, an enable input and an `expired` output.

## Test plan
- Frame A5 00 0F 00 02 12 34 AB CD: `pg_wr` pulses at 000F/1234 and 0010/ABCD, `words_loaded`=2, `cpu_rst` high 4 cycles, `pgm` falls with it.
- Frame A5 FF FF 00 02 …: writes go to addresses FFFF then 0000, demonstrating wrap.
- CNT=0 frame: no `pg_wr`, RELEASE entered immediately after CNT_L.
- Stall `rx_valid` for `TIMEOUT_CYC` cycles after ADDR_L: `err`=1, `pgm` stays 1. A following valid frame clears `err` and completes normally.
- Assert `rst` between DATA_H and DATA_L: no write occurs, and all outputs return to reset values next cycle.
- With the macro: a correct XOR byte leads to release; a corrupted byte leads to `err`=1, no `cpu_rst`, `pgm` held.
